// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the generic pipeline stage register.
//   - default payload / control / write-register widths
//   - bit positions of the control bits carried in the ctrl field
//   - pipe_entry_t: one pipeline entry at the default widths
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_DW  = 16;
    localparam int DEF_CW  = 5;
    localparam int DEF_RW  = 3;
    localparam int DEF_SCW = 16;

    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_DMEMEN   = 2;
    localparam int CTRL_JUMP     = 3;
    localparam int CTRL_BRANCH   = 4;

    typedef struct packed {
        logic [DEF_DW-1:0] data;
        logic [DEF_CW-1:0] ctrl;
        logic [DEF_RW-1:0] wreg;
    } pipe_entry_t;

endpackage

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One entry register of a pipeline stage: a valid flag plus the entry itself.
// The entry type is a parameter so the stage can use its own widths.
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset (valid and entry cleared)
//   i_load   capture i_d and mark valid
//   i_clear  mark empty; wins over i_load; entry contents are left stale
//   i_d      entry to capture
//   o_valid  slot holds an entry
//   o_q      held entry
// -----------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter type T = pipe_entry_t
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_clear,
    input  T     i_d,
    output logic o_valid,
    output T     o_q
);

    logic r_valid;
    T     r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_q     <= i_d;
        end
    end

    assign o_valid = r_valid;
    assign o_q     = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register with valid/ready handshake, flush, optional
// 2-entry skid buffer and a saturating stall counter.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    synchronous kill of held and incoming entries
//   in_valid/in_ready        upstream handshake
//   in_data/in_ctrl/in_wreg  incoming entry
//   out_valid/out_ready      downstream handshake
//   out_data/out_ctrl/...    head entry; out_ctrl forced 0 on a bubble
//   stall_cnt                cycles with out_valid & ~out_ready (saturating)
//   stall_cnt_clr            synchronous clear of stall_cnt
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int CW   = DEF_CW,
    parameter int RW   = DEF_RW,
    parameter int SKID = 1,
    parameter int SCW  = DEF_SCW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  in_data,
    input  logic [CW-1:0]  in_ctrl,
    input  logic [RW-1:0]  in_wreg,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic [CW-1:0]  out_ctrl,
    output logic [RW-1:0]  out_wreg,
    output logic [SCW-1:0] stall_cnt,
    input  logic           stall_cnt_clr
);

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ctrl;
        logic [RW-1:0] wreg;
    } entry_t;

    entry_t w_in_entry;
    entry_t w_main_d;
    entry_t w_main_q;
    logic   w_main_v;
    logic   w_main_load;
    logic   w_main_clear;
    logic   w_in_xfer;
    logic   w_out_xfer;

    logic [SCW-1:0] r_stall_cnt;

    assign w_in_entry = {in_data, in_ctrl, in_wreg};
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = w_main_v & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            entry_t w_skid_q;
            logic   w_skid_v;
            logic   w_skid_load;
            logic   w_skid_clear;

            // in_ready is the inverted skid valid flop, so it never depends
            // combinationally on out_ready.
            assign in_ready = ~w_skid_v;

            // Main refills from skid first to keep strict FIFO order; with
            // skid occupied in_ready is low, so no input can race it.
            assign w_main_d     = w_skid_v ? w_skid_q : w_in_entry;
            assign w_main_load  = ~flush & ((w_out_xfer & (w_skid_v | w_in_xfer)) |
                                            (~w_main_v & w_in_xfer));
            assign w_main_clear = flush | (w_out_xfer & ~w_skid_v & ~w_in_xfer);

            assign w_skid_load  = ~flush & ~w_out_xfer & w_in_xfer & w_main_v;
            assign w_skid_clear = flush | (w_out_xfer & w_skid_v);

            pipe_slot #(.T(entry_t)) u_skid (
                .i_clk   (clk),
                .i_rst   (rst),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_d     (w_in_entry),
                .o_valid (w_skid_v),
                .o_q     (w_skid_q)
            );
        end else begin : g_single
            assign in_ready     = out_ready | ~w_main_v;
            assign w_main_d     = w_in_entry;
            assign w_main_load  = ~flush & w_in_xfer;
            assign w_main_clear = flush | (w_out_xfer & ~w_in_xfer);
        end
    endgenerate

    pipe_slot #(.T(entry_t)) u_main (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_d     (w_main_d),
        .o_valid (w_main_v),
        .o_q     (w_main_q)
    );

    assign out_valid = w_main_v;
    assign out_data  = w_main_q.data;
    assign out_wreg  = w_main_q.wreg;
    // A bubble must never carry live control bits (RegWrite, DMemEn, ...).
    assign out_ctrl  = w_main_v ? w_main_q.ctrl : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            r_stall_cnt <= '0;
        end else if (w_main_v & ~out_ready & ~(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
